// File: rtl/bnn_seq_ctrl.sv
// Sequencing controller for the 8-8-4 BNN core: weight-load serialiser and inference issuer.
// Optional macro BNN_SEQ_STATS_EN enables the saturating completed-inference counter.
module bnn_seq_ctrl #(
    parameter int unsigned NUM_NEURONS = 12,
    parameter int unsigned PIPE_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        w_valid,
    input  logic [7:0]  w_data,
    output logic        w_ready,
    input  logic        x_valid,
    input  logic [7:0]  x_data,
    output logic        x_ready,
    output logic        y_valid,
    output logic [3:0]  y_data,
    input  logic        y_ready,
    output logic        busy,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] infer_cnt,
    output logic [7:0]  bnn_x,
    output logic        bnn_load_en,
    output logic [3:0]  bnn_nibble,
    input  logic [3:0]  bnn_y
);

    localparam int unsigned CntW  = $clog2(NUM_NEURONS + 1);
    localparam int unsigned WaitW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLdWait,
        StLdLo,
        StLdHi,
        StInfWait,
        StResult
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]        x_q, x_d;
    logic [3:0]        y_q, y_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              pending_q, pending_d;
    logic              load_req;

    assign load_req = load_start | pending_q;

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        pending_d   = pending_q;
        w_ready     = 1'b0;
        x_ready     = 1'b0;
        bnn_load_en = 1'b0;
        bnn_nibble  = 4'h0;

        // Requests seen while busy are remembered and serviced on the next idle cycle.
        if (state_q != StIdle && load_start) begin
            pending_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                x_ready = ~load_req & ~reset;
                if (load_req) begin
                    pending_d = 1'b0;
                    // The core's neuron index only rewinds on reset: one session per reset.
                    if (load_done_q) begin
                        load_err_d = 1'b1;
                    end else begin
                        byte_cnt_d = '0;
                        state_d    = StLdWait;
                    end
                end else if (x_valid) begin
                    x_d        = x_data;
                    wait_cnt_d = '0;
                    state_d    = StInfWait;
                end
            end
            StLdWait: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    byte_d  = w_data;
                    state_d = StLdLo;
                end
            end
            StLdLo: begin
                bnn_load_en = 1'b1;
                bnn_nibble  = byte_q[3:0];
                state_d     = StLdHi;
            end
            StLdHi: begin
                bnn_load_en = 1'b1;
                bnn_nibble  = byte_q[7:4];
                byte_cnt_d  = byte_cnt_q + CntW'(1);
                if (byte_cnt_q == CntW'(NUM_NEURONS - 1)) begin
                    load_done_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    state_d = StLdWait;
                end
            end
            StInfWait: begin
                if (wait_cnt_q == WaitW'(PIPE_LAT)) begin
                    y_d     = bnn_y;
                    state_d = StResult;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StResult: begin
                if (y_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            byte_q      <= 8'h00;
            byte_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            x_q         <= 8'h00;
            y_q         <= 4'h0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            byte_cnt_q  <= byte_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            pending_q   <= pending_d;
        end
    end

    assign y_valid   = (state_q == StResult);
    assign y_data    = y_q;
    assign busy      = (state_q != StIdle);
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign bnn_x     = x_q;

`ifdef BNN_SEQ_STATS_EN
    logic [15:0] infer_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            infer_cnt_q <= 16'h0000;
        end else if (y_valid && y_ready && infer_cnt_q != 16'hFFFF) begin
            infer_cnt_q <= infer_cnt_q + 16'd1;
        end
    end

    assign infer_cnt = infer_cnt_q;
`else
    assign infer_cnt = 16'h0000;
`endif

endmodule
